// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with variable-latency memories under a watchdog, and counts retired instructions.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int TO_W        = 8
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [10:0]      Opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCSrc,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             illegal_op,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NOP     = 3'd0,
    C_RTYPE   = 3'd1,
    C_LDUR    = 3'd2,
    C_STUR    = 3'd3,
    C_CBZ     = 3'd4,
    C_B       = 3'd5,
    C_ILLEGAL = 3'd6
  } op_class_t;

  // A timeout of zero disables the watchdog; WD_LAST is then never consulted.
  localparam bit             WD_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(MEM_TIMEOUT - 1);

  function automatic op_class_t decode_op(input logic [10:0] op);
    op_class_t c;
    c = C_ILLEGAL;
    casez (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: c = C_RTYPE;
      11'b11111000010: c = C_LDUR;
      11'b11111000000: c = C_STUR;
      11'b10110100???: c = C_CBZ;
      11'b000101?????: c = C_B;
      default:         c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  state_t            state_r, state_s;
  op_class_t         class_r, class_s;
  logic [TO_W-1:0]   wait_cnt_r, wait_s;
  logic [CNT_W-1:0]  retired_r;
  logic              retire_s;
  op_class_t         dec_class_s;
  logic              wd_expire_s;
  logic              rb_from_rd_s;

  assign dec_class_s  = decode_op(Opcode);
  assign wd_expire_s  = WD_EN && (wait_cnt_r == WD_LAST);
  assign rb_from_rd_s = (class_r == C_STUR) || (class_r == C_CBZ);
  assign state_o      = state_r;
  assign retired      = retired_r;

  // State, latched class, watchdog and retire counter registers.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_r    <= S_FETCH;
      class_r    <= C_NOP;
      wait_cnt_r <= {TO_W{1'b0}};
      retired_r  <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      class_r    <= class_s;
      wait_cnt_r <= wait_s;
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  // Next-state, watchdog and control-output decode.
  always_comb begin
    state_s     = state_r;
    class_s     = class_r;
    wait_s      = {TO_W{1'b0}};
    retire_s    = 1'b0;
    imem_req    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 1'b0;
    Reg2Loc     = 1'b0;
    ALUSrc      = 1'b0;
    ALUOp       = 2'b00;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    illegal_op  = 1'b0;
    fault       = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = 1'b0;
          state_s = S_DECODE;
        end else if (wd_expire_s) begin
          state_s = S_FAULT;
        end else begin
          wait_s = wait_cnt_r + TO_W'(1);
        end
      end
      S_DECODE: begin
        class_s = dec_class_s;
        // Reg2Loc must be valid while the register file is read this cycle.
        Reg2Loc = (dec_class_s == C_STUR) || (dec_class_s == C_CBZ);
        if (dec_class_s == C_ILLEGAL) begin
          illegal_op = 1'b1;
          state_s    = S_FETCH;
        end else begin
          state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        Reg2Loc = rb_from_rd_s;
        case (class_r)
          C_RTYPE: begin
            ALUOp   = 2'b10;
            state_s = S_WB;
          end
          C_LDUR, C_STUR: begin
            ALUOp   = 2'b00;
            ALUSrc  = 1'b1;
            state_s = S_MEM;
          end
          C_CBZ: begin
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSrc       = 1'b1;
            state_s     = S_FETCH;
            retire_s    = 1'b1;
          end
          C_B: begin
            PCWrite  = 1'b1;
            PCSrc    = 1'b1;
            state_s  = S_FETCH;
            retire_s = 1'b1;
          end
          default: begin
            state_s = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        ALUOp    = 2'b00;
        ALUSrc   = 1'b1;
        Reg2Loc  = rb_from_rd_s;
        MemRead  = (class_r == C_LDUR);
        MemWrite = (class_r == C_STUR);
        if (dmem_ready) begin
          if (class_r == C_LDUR) begin
            state_s = S_WB;
          end else begin
            state_s  = S_FETCH;
            retire_s = (class_r == C_STUR);
          end
        end else if (wd_expire_s) begin
          state_s = S_FAULT;
        end else begin
          wait_s = wait_cnt_r + TO_W'(1);
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = (class_r == C_LDUR);
        state_s  = S_FETCH;
        retire_s = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_s = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations queued by the stimulus,
// popped and compared by an independent monitor; a CNT_W=4 twin checks counter wrap.
module tb_multicycle_control;

  localparam logic [14:0] IREQ = 15'h0001, IRW  = 15'h0002, PCW  = 15'h0004;
  localparam logic [14:0] PCWC = 15'h0008, PCS  = 15'h0010, R2L  = 15'h0020;
  localparam logic [14:0] ASRC = 15'h0040, OP01 = 15'h0080, OP10 = 15'h0100;
  localparam logic [14:0] MRD  = 15'h0200, MWR  = 15'h0400, M2R  = 15'h0800;
  localparam logic [14:0] RW   = 15'h1000, ILL  = 15'h2000, FLT  = 15'h4000;
  localparam logic [14:0] NONE = 15'h0000;

  localparam logic [10:0] OP_ADD  = 11'b10001011000, OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000, OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010, OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101, OP_B    = 11'b00010110110;
  localparam logic [10:0] OP_BAD1 = 11'b11111111111, OP_BAD2 = 11'b11001011001;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_ILL = 5;

  typedef struct packed {
    logic [2:0]  st;
    logic [14:0] ctl;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset_L = 1'b0;
  logic [10:0] Opcode = 11'd0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;

  logic        imem_req, IRWrite, PCWrite, PCWriteCond, PCSrc, Reg2Loc, ALUSrc;
  logic [1:0]  ALUOp;
  logic        MemRead, MemWrite, MemToReg, RegWrite, illegal_op, fault;
  logic [2:0]  state_o;
  logic [31:0] retired;

  logic        d2_imem_req, d2_IRWrite, d2_PCWrite, d2_PCWriteCond, d2_PCSrc, d2_Reg2Loc, d2_ALUSrc;
  logic [1:0]  d2_ALUOp;
  logic        d2_MemRead, d2_MemWrite, d2_MemToReg, d2_RegWrite, d2_illegal_op, d2_fault;
  logic [2:0]  d2_state_o;
  logic [3:0]  d2_retired;

  logic [14:0] act_ctl, d2_ctl;
  exp_t        sb_q[$];
  logic [31:0] exp_ret = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  event        async_ev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(32), .TO_W(8)) dut (
    .CLK(clk), .Reset_L(Reset_L), .Opcode(Opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite), .illegal_op(illegal_op),
    .fault(fault), .state_o(state_o), .retired(retired)
  );

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(4), .TO_W(8)) dut_w4 (
    .CLK(clk), .Reset_L(Reset_L), .Opcode(Opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(d2_imem_req), .IRWrite(d2_IRWrite), .PCWrite(d2_PCWrite), .PCWriteCond(d2_PCWriteCond),
    .PCSrc(d2_PCSrc), .Reg2Loc(d2_Reg2Loc), .ALUSrc(d2_ALUSrc), .ALUOp(d2_ALUOp), .MemRead(d2_MemRead),
    .MemWrite(d2_MemWrite), .MemToReg(d2_MemToReg), .RegWrite(d2_RegWrite), .illegal_op(d2_illegal_op),
    .fault(d2_fault), .state_o(d2_state_o), .retired(d2_retired)
  );

  assign act_ctl = {fault, illegal_op, RegWrite, MemToReg, MemWrite, MemRead, ALUOp, ALUSrc,
                    Reg2Loc, PCSrc, PCWriteCond, PCWrite, IRWrite, imem_req};
  assign d2_ctl  = {d2_fault, d2_illegal_op, d2_RegWrite, d2_MemToReg, d2_MemWrite, d2_MemRead,
                    d2_ALUOp, d2_ALUSrc, d2_Reg2Loc, d2_PCSrc, d2_PCWriteCond, d2_PCWrite,
                    d2_IRWrite, d2_imem_req};

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp = n_cmp + 1;
    if (act !== expv) begin
      n_bad = n_bad + 1;
      $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", nm, cyc, act, expv);
    end
  endtask

  // Monitor: consumes one expectation per sampled cycle (or on an async-reset probe).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or async_ev);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        cmp("state",    {29'd0, state_o},    {29'd0, e.st});
        cmp("ctl",      {17'd0, act_ctl},    {17'd0, e.ctl});
        cmp("retired",  retired,             e.ret);
        cmp("state_w4", {29'd0, d2_state_o}, {29'd0, e.st});
        cmp("ctl_w4",   {17'd0, d2_ctl},     {17'd0, e.ctl});
        cmp("retired_w4", {28'd0, d2_retired}, {28'd0, e.ret[3:0]});
      end
    end
  end

  task automatic step(input logic [2:0] st, input logic [14:0] c, input logic im, input logic dm);
    exp_t e;
    imem_ready = im;
    dmem_ready = dm;
    e.st  = st;
    e.ctl = c;
    e.ret = exp_ret;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_L = 1'b0;
    exp_ret = 32'd0;
    step(3'd0, IREQ, 1'b0, 1'b0);
    Reset_L = 1'b1;
  endtask

  task automatic run_instr(input logic [10:0] op, input int kind, input int iw, input int dw);
    Opcode = op;
    repeat (iw) step(3'd0, IREQ, 1'b0, 1'b0);
    step(3'd0, IREQ | IRW | PCW, 1'b1, 1'b0);
    case (kind)
      K_R: begin
        step(3'd1, NONE, 1'b0, 1'b0);
        step(3'd2, OP10, 1'b0, 1'b0);
        step(3'd4, RW, 1'b0, 1'b0);
        exp_ret = exp_ret + 32'd1;
      end
      K_LD: begin
        step(3'd1, NONE, 1'b0, 1'b0);
        step(3'd2, ASRC, 1'b0, 1'b0);
        repeat (dw) step(3'd3, ASRC | MRD, 1'b0, 1'b0);
        step(3'd3, ASRC | MRD, 1'b0, 1'b1);
        step(3'd4, RW | M2R, 1'b0, 1'b0);
        exp_ret = exp_ret + 32'd1;
      end
      K_ST: begin
        step(3'd1, R2L, 1'b0, 1'b0);
        step(3'd2, ASRC | R2L, 1'b0, 1'b0);
        repeat (dw) step(3'd3, ASRC | MWR | R2L, 1'b0, 1'b0);
        step(3'd3, ASRC | MWR | R2L, 1'b0, 1'b1);
        exp_ret = exp_ret + 32'd1;
      end
      K_CBZ: begin
        step(3'd1, R2L, 1'b0, 1'b0);
        step(3'd2, OP01 | PCWC | PCS | R2L, 1'b0, 1'b0);
        exp_ret = exp_ret + 32'd1;
      end
      K_B: begin
        step(3'd1, NONE, 1'b0, 1'b0);
        step(3'd2, PCW | PCS, 1'b0, 1'b0);
        exp_ret = exp_ret + 32'd1;
      end
      default: begin
        step(3'd1, ILL, 1'b0, 1'b0);
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    run_instr(OP_ADD, K_R, 0, 0);
    run_instr(OP_LDUR, K_LD, 0, 3);
    run_instr(OP_STUR, K_ST, 0, 3);
    run_instr(OP_CBZ, K_CBZ, 0, 0);
    run_instr(OP_B, K_B, 0, 0);
    run_instr(OP_SUB, K_R, 2, 0);
    run_instr(OP_AND, K_R, 1, 0);
    run_instr(OP_ORR, K_R, 0, 0);
    run_instr(OP_LDUR, K_LD, 0, 0);
    run_instr(OP_STUR, K_ST, 0, 0);
    run_instr(OP_BAD1, K_ILL, 0, 0);
    run_instr(OP_BAD2, K_ILL, 0, 0);
    step(3'd0, IREQ, 1'b0, 1'b0);

    // Counter wrap on the 4-bit twin: 17 retirements leave it at 1.
    do_reset();
    repeat (17) run_instr(OP_ADD, K_R, 0, 0);
    step(3'd0, IREQ, 1'b0, 1'b0);

    // Fetch watchdog: 16 not-ready cycles fault, and the fault is sticky.
    do_reset();
    repeat (16) step(3'd0, IREQ, 1'b0, 1'b0);
    step(3'd7, FLT, 1'b0, 1'b0);
    step(3'd7, FLT, 1'b1, 1'b1);
    step(3'd7, FLT, 1'b1, 1'b1);

    // Ready on the 16th cycle wins over the watchdog.
    do_reset();
    run_instr(OP_ADD, K_R, 15, 0);
    step(3'd0, IREQ, 1'b0, 1'b0);

    // Asynchronous reset while a store waits in MEM.
    Opcode = OP_STUR;
    step(3'd0, IREQ | IRW | PCW, 1'b1, 1'b0);
    step(3'd1, R2L, 1'b0, 1'b0);
    step(3'd2, ASRC | R2L, 1'b0, 1'b0);
    step(3'd3, ASRC | MWR | R2L, 1'b0, 1'b0);
    Reset_L = 1'b0;
    #1;
    exp_ret = 32'd0;
    begin
      exp_t e;
      e.st  = 3'd0;
      e.ctl = IREQ;
      e.ret = exp_ret;
      sb_q.push_back(e);
    end
    -> async_ev;
    #1;
    @(posedge clk);
    #1;
    Reset_L = 1'b1;
    run_instr(OP_ADD, K_R, 0, 0);
    step(3'd0, IREQ, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
